data_memory_pipe: RTL

- Parametrised successor to the CPU's single-port data memory.
- Uses a valid/ready request interface and a fixed-latency read pipeline of RD_LATENCY cycles.
- Adds address bounds checking with an error flag, and a hardware clear sequencer that zeroes the array after reset or on command.
- Sits between the execute/memory stage and the data array; accepts one request per cycle.

---
 rtl/data_memory_pipe.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/data_memory_pipe.sv
// data_memory_pipe: single-port data memory with a valid/ready request port,
// a fixed-latency response pipeline, address bounds checking, and a clear
// sequencer that zeroes the whole array after reset or on command.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is combinational and low during INIT and in any READY cycle where
// clear is asserted, so a clear always wins over a simultaneous request.
// Every transferred request yields exactly one rsp_valid pulse RD_LATENCY
// cycles later; rsp_valid has no back-pressure.
//
// State visibility: init_done is high exactly in READY, so it doubles as the
// state observation point for the two-state sequencer.
module data_memory_pipe #(
   parameter int DATA_WIDTH = 19,
   parameter int ADDR_WIDTH = 19,
   parameter int DEPTH      = 512,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic                  clear,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  init_done
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // DEPTH may equal 2^ADDR_WIDTH, so the bound needs one extra bit.
   localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                  state, state_nxt;
   logic [IDX_W-1:0]        cnt, cnt_nxt;
   logic                    in_range;
   logic                    accept;
   logic [IDX_W-1:0]        req_idx;
   logic                    mem_we;
   logic [IDX_W-1:0]        mem_waddr;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic [DATA_WIDTH-1:0]   rd_sample;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic [RD_LATENCY-1:0]   pipe_v;
   logic [RD_LATENCY-1:0]   pipe_e;
   logic [DATA_WIDTH-1:0]   pipe_d [RD_LATENCY];

   // Full-width compare: no truncation, so aliases above DEPTH are rejected.
   assign in_range = {1'b0, req_addr} < DEPTH_EXT;
   assign req_idx  = req_addr[IDX_W-1:0];

   // Sequencer state and clear counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state: INIT walks cnt over every word once, READY waits for clear.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_INIT: begin
            if (cnt == LAST_IDX) begin
               state_nxt = ST_READY;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_READY: begin
            if (clear) begin
               state_nxt = ST_INIT;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = ST_INIT;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs and array write port: INIT owns the port, READY serves requests.
   always_comb begin
      init_done = (state == ST_READY);
      req_ready = (state == ST_READY) && !clear;
      accept    = req_valid && req_ready;
      if (state == ST_INIT) begin
         mem_we    = 1'b1;
         mem_waddr = cnt;
         mem_wdata = '0;
      end else begin
         mem_we    = accept && req_write && in_range;
         mem_waddr = req_idx;
         mem_wdata = req_wdata;
      end
   end

   // Read sample taken at the acceptance edge; zero for writes and errors.
   always_comb begin
      rd_sample = '0;
      if (accept && !req_write && in_range) begin
         rd_sample = mem[req_idx];
      end
   end

   // Data array: not reset, the INIT sweep zeroes it.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // Response shift register; reset drops everything in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_v <= '0;
         pipe_e <= '0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_d[i] <= '0;
         end
      end else begin
         pipe_v[0] <= accept;
         pipe_e[0] <= accept && !in_range;
         pipe_d[0] <= rd_sample;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_e[i] <= pipe_e[i-1];
            pipe_d[i] <= pipe_d[i-1];
         end
      end
   end

   // Err and data are already zero in empty stages, so no extra gating.
   assign rsp_valid = pipe_v[RD_LATENCY-1];
   assign rsp_err   = pipe_e[RD_LATENCY-1];
   assign rsp_rdata = pipe_d[RD_LATENCY-1];

endmodule
